// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver
// SPI master capture front end: drives chip-select and mode-0 bit clock,
// deserialises MSB-first words from spi_mosi into a small FIFO and hands
// them out one per sample_req pulse. A frame is only started when a FIFO
// slot is free, so the in-flight word always has somewhere to land.
module spi_frame_receiver #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int CLK_DIV      = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int CS_IDLE      = 8
) (
    input  logic                          input_clk,
    input  logic                          reset,
    input  logic                          spi_mosi,
    output logic                          spi_cs,
    output logic                          spi_sclk,
    input  logic                          sample_req,
    output logic [SAMPLE_WIDTH-1:0]       sample_out,
    output logic                          sample_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    input  logic                          clear_flags
);

    localparam int HALF = CLK_DIV / 2;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int LW   = PW + 1;
    localparam int CMAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(SAMPLE_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
    logic                    cs_q, cs_d;
    logic                    sclk_q, sclk_d;
    logic                    push_q, push_d;

    logic [SAMPLE_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]           level_q, level_d;
    logic [SAMPLE_WIDTH-1:0] out_q;
    logic                    valid_q;
    logic                    uf_q, uf_d;
    logic                    pop;

    // Frame sequencing: next state, phase/bit counters and registered bus outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        push_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q < LW'(FIFO_DEPTH)) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                end
            end
            SETUP: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (bit_q == BW'(SAMPLE_WIDTH - 1)) begin
                        state_d = GAP;
                        push_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CW'(CS_IDLE - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are derived from the next state so they register in step with it.
        cs_d    = !((state_d == SETUP) || (state_d == SHIFT));
        sclk_d  = (state_d == SHIFT) && (cnt_d >= CW'(HALF));
        // Capture on the edge where sclk goes 0->1.
        shift_d = (sclk_d && !sclk_q) ? {shift_q[SAMPLE_WIDTH-2:0], spi_mosi} : shift_q;
    end

    // FSM state register and SPI-side datapath.
    always_ff @(posedge input_clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            push_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            push_q  <= push_d;
        end
    end

    // FIFO bookkeeping: level tracks push minus pop; set wins over clear for underflow.
    always_comb begin
        pop     = sample_req && (level_q != '0);
        level_d = level_q + LW'(push_q) - LW'(pop);
        uf_d    = uf_q;
        if (clear_flags)
            uf_d = 1'b0;
        if (sample_req && (level_q == '0))
            uf_d = 1'b1;
    end

    // Pointers, level, delivery register and sticky flag.
    always_ff @(posedge input_clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            uf_q     <= 1'b0;
        end else begin
            level_q <= level_d;
            uf_q    <= uf_d;
            valid_q <= pop;
            if (push_q)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                out_q    <= mem_q[rd_ptr_q];
            end
        end
    end

    // Sample storage; completed word lands one cycle after the frame ends.
    always_ff @(posedge input_clk) begin
        if (reset && push_q)
            mem_q[wr_ptr_q] <= shift_q;
    end

    assign spi_cs       = cs_q;
    assign spi_sclk     = sclk_q;
    assign sample_out   = out_q;
    assign sample_valid = valid_q;
    assign fifo_level   = level_q;
    assign underflow    = uf_q;

endmodule
